// File: rtl/freq_meter_bcd_pkg.sv
// Shared definitions for the BCD frequency meter: digit width, digit
// constants and the mod-10 increment helper.
package freq_meter_pkg;

  localparam int          BCD_W          = 4;
  localparam logic [3:0]  BCD_NINE       = 4'd9;
  localparam int          DEFAULT_CLK_HZ = 50_000_000;

  typedef logic [BCD_W-1:0] bcd_t;

  // Mod-10 increment of one BCD digit; 9 rolls over to 0.
  function automatic bcd_t bcd_incr(input bcd_t d);
    bcd_t r;
    if (d == BCD_NINE) begin
      r = 4'd0;
    end else begin
      r = d + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/freq_meter_bcd_digit.sv
// One mod-10 counter digit of the BCD chain. Carry gating lives in the
// parent; this digit only knows how to load, increment and report "is 9".
module bcd_digit
  import freq_meter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  output logic [BCD_W-1:0] digit,
  output logic             is_nine
);

  bcd_t digit_q;
  bcd_t digit_d;

  // Next digit value: load wins over increment, otherwise hold.
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_val;
    end else if (inc) begin
      digit_d = bcd_incr(digit_q);
    end else begin
      digit_d = digit_q;
    end
  end

  // Digit storage with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit   = digit_q;
  assign is_nine = (digit_q == BCD_NINE);

endmodule

// File: rtl/freq_meter_bcd.sv
// Frequency meter: counts rising edges of an asynchronous input over a
// CLK_HZ-cycle gate window and publishes the count as packed BCD.
// The gate timer is free-running from reset; the first valid pulse appears
// on the CLK_HZ-th clk rise after reset release, then every CLK_HZ cycles.
module freq_meter_bcd
  import freq_meter_pkg::*;
#(
  parameter int CLK_HZ = DEFAULT_CLK_HZ,
  parameter int DIGITS = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sig_in,
  output logic [BCD_W*DIGITS-1:0] bcd_out,
  output logic                    overflow,
  output logic                    valid
);

  localparam int             TW     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [TW-1:0]  TC_VAL = TW'(CLK_HZ - 1);

  // Input synchronizer plus edge-history register.
  logic sync1_q;
  logic sync2_q;
  logic sync3_q;
  logic edge_s;

  // Gate timer.
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic          tc_s;

  // BCD chain.
  bcd_t                    digit_s [DIGITS];
  logic [DIGITS-1:0]       is_nine_s;
  logic [DIGITS-1:0]       carry_s;
  logic [DIGITS-1:0]       inc_s;
  logic [BCD_W*DIGITS-1:0] chain_s;
  logic                    all_nine_s;

  // Saturation flag for the window in progress.
  logic ovf_q;
  logic ovf_d;

  // Registered outputs.
  logic [BCD_W*DIGITS-1:0] bcd_q;
  logic [BCD_W*DIGITS-1:0] bcd_d;
  logic                    ovf_out_q;
  logic                    ovf_out_d;
  logic                    valid_q;
  logic                    valid_d;

  // Two-flop synchronizer followed by a history flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign edge_s = sync2_q & ~sync3_q;
  assign tc_s   = (timer_q == TC_VAL);

  // Free-running gate timer: 0..CLK_HZ-1 then wrap.
  always_comb begin
    timer_d = timer_q;
    if (tc_s) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  // Gate timer storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign all_nine_s = &is_nine_s;

  // Digit k advances when every lower digit is 9; the whole chain freezes
  // once it reads all nines. On TC the chain reloads instead of counting,
  // seeding digit 0 with an edge that lands on TC so it is not lost.
  genvar k;
  generate
    for (k = 0; k < DIGITS; k++) begin : g_digit
      bcd_t load_val_s;

      if (k == 0) begin : g_first
        assign carry_s[k]  = edge_s & ~all_nine_s;
        assign load_val_s  = BCD_W'(edge_s);
      end else begin : g_rest
        assign carry_s[k]  = carry_s[k-1] & is_nine_s[k-1];
        assign load_val_s  = '0;
      end

      assign inc_s[k] = carry_s[k] & ~tc_s;
      assign chain_s[k*BCD_W +: BCD_W] = digit_s[k];

      bcd_digit u_digit (
        .clk      (clk),
        .reset    (reset),
        .inc      (inc_s[k]),
        .load     (tc_s),
        .load_val (load_val_s),
        .digit    (digit_s[k]),
        .is_nine  (is_nine_s[k])
      );
    end
  endgenerate

  // Window overflow flag: set by an edge arriving at full scale, cleared on TC.
  always_comb begin
    ovf_d = ovf_q;
    if (tc_s) begin
      ovf_d = 1'b0;
    end else if (edge_s && all_nine_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Output capture: on TC publish the chain value from before this cycle's edge.
  always_comb begin
    bcd_d     = bcd_q;
    ovf_out_d = ovf_out_q;
    valid_d   = 1'b0;
    if (tc_s) begin
      bcd_d     = chain_s;
      ovf_out_d = ovf_q;
      valid_d   = 1'b1;
    end else begin
      bcd_d     = bcd_q;
      ovf_out_d = ovf_out_q;
      valid_d   = 1'b0;
    end
  end

  // Overflow flag and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
      ovf_out_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      ovf_q     <= ovf_d;
      bcd_q     <= bcd_d;
      ovf_out_q <= ovf_out_d;
      valid_q   <= valid_d;
    end
  end

  assign bcd_out  = bcd_q;
  assign overflow = ovf_out_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_freq_meter_bcd.sv
// Directed bench for freq_meter_bcd: two instances (3 digits and 1 digit)
// share clock, reset and input; expected readings are hand-computed.
module tb_freq_meter_bcd;

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic        sig_in = 1'b0;
  logic [11:0] bcd_a;
  logic        ovf_a;
  logic        valid_a;
  logic [3:0]  bcd_b;
  logic        ovf_b;
  logic        valid_b;

  int   n_checks = 0;
  int   n_errors = 0;
  int   mode     = 0;     // 0: manual level, 1: period 10, 2: period 2, 3: period 4
  logic man_lvl  = 1'b0;
  int   gen_cnt  = 0;

  freq_meter_bcd #(.CLK_HZ(100), .DIGITS(3)) u_dut_a (
    .clk      (clk),
    .reset    (reset),
    .sig_in   (sig_in),
    .bcd_out  (bcd_a),
    .overflow (ovf_a),
    .valid    (valid_a)
  );

  freq_meter_bcd #(.CLK_HZ(100), .DIGITS(1)) u_dut_b (
    .clk      (clk),
    .reset    (reset),
    .sig_in   (sig_in),
    .bcd_out  (bcd_b),
    .overflow (ovf_b),
    .valid    (valid_b)
  );

  always #5 clk = ~clk;

  // Input pattern generator, updates on the falling edge.
  always @(negedge clk) begin
    gen_cnt = gen_cnt + 1;
    case (mode)
      1:       sig_in = ((gen_cnt % 10) < 5);
      2:       sig_in = ((gen_cnt % 2) == 0);
      3:       sig_in = ((gen_cnt % 4) < 2);
      default: sig_in = man_lvl;
    endcase
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Wait for the next valid pulse on instance A, sampling 1 time unit after
  // each rise; returns the number of rises waited (0 on timeout).
  task automatic wait_valid(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (valid_a) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL valid_timeout: got no valid within 300 cycles, expected one within 100");
    end
  endtask

  typedef struct {
    int          mode;
    logic [11:0] bcd_a;
    logic        ovf_a;
    logic [3:0]  bcd_b;
    logic        ovf_b;
    string       name;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int c;
    int sum;
    bit saw_valid;

    vecs[0] = '{1, 12'h010, 1'b0, 4'h9, 1'b1, "period10"};
    vecs[1] = '{2, 12'h050, 1'b0, 4'h9, 1'b1, "period2"};
    vecs[2] = '{3, 12'h025, 1'b0, 4'h9, 1'b1, "period4"};
    vecs[3] = '{0, 12'h000, 1'b0, 4'h0, 1'b0, "idle"};

    // Reset state.
    #3 reset = 1'b1;
    #1;
    check("rst_bcd_a", bcd_a, 12'h000);
    check("rst_ovf_a", ovf_a, 1'b0);
    check("rst_valid_a", valid_a, 1'b0);
    check("rst_bcd_b", bcd_b, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // First valid on the 100th rise after release, idle input.
    wait_valid(c);
    check("first_valid_cycle", c, 100);
    check("idle_first_bcd", bcd_a, 12'h000);
    wait_valid(c);
    check("idle_spacing", c, 100);
    check("idle_bcd", bcd_a, 12'h000);

    // Steady-state readings per input pattern (skip one mixed window).
    for (int v = 0; v < 4; v++) begin
      mode    = vecs[v].mode;
      man_lvl = 1'b0;
      wait_valid(c);
      for (int r = 0; r < 2; r++) begin
        wait_valid(c);
        check({vecs[v].name, "_spacing"}, c, 100);
        check({vecs[v].name, "_bcd_a"}, bcd_a, vecs[v].bcd_a);
        check({vecs[v].name, "_ovf_a"}, ovf_a, vecs[v].ovf_a);
        check({vecs[v].name, "_bcd_b"}, bcd_b, vecs[v].bcd_b);
        check({vecs[v].name, "_ovf_b"}, ovf_b, vecs[v].ovf_b);
        check({vecs[v].name, "_valid_b"}, valid_b, 1'b1);
      end
    end

    // Single edge detected exactly on TC: belongs to the next window.
    mode    = 0;
    man_lvl = 1'b0;
    wait_valid(c);
    repeat (97) @(posedge clk);
    #1 man_lvl = 1'b1;
    wait_valid(c);
    sum = int'(bcd_a);
    check("tc_edge_win_n", bcd_a, 12'h000);
    wait_valid(c);
    sum += int'(bcd_a);
    check("tc_edge_win_n1", bcd_a, 12'h001);
    man_lvl = 1'b0;
    wait_valid(c);
    sum += int'(bcd_a);
    check("tc_edge_win_n2", bcd_a, 12'h000);
    check("tc_edge_sum", sum, 1);

    // Single edge detected one cycle before TC: stays in the current window.
    repeat (96) @(posedge clk);
    #1 man_lvl = 1'b1;
    wait_valid(c);
    check("pre_tc_edge_win_n", bcd_a, 12'h001);
    wait_valid(c);
    check("pre_tc_edge_win_n1", bcd_a, 12'h000);
    man_lvl = 1'b0;

    // Reset in the middle of a window with period-10 input.
    mode = 1;
    wait_valid(c);
    wait_valid(c);
    check("pre_rst_bcd_a", bcd_a, 12'h010);
    repeat (50) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_bcd_a", bcd_a, 12'h000);
    check("midrst_ovf_b", ovf_b, 1'b0);
    check("midrst_bcd_b", bcd_b, 4'h0);
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (valid_a || valid_b) saw_valid = 1'b1;
    end
    check("midrst_no_valid", saw_valid, 1'b0);
    @(negedge clk) reset = 1'b0;
    wait_valid(c);
    check("midrst_first_valid_cycle", c, 100);
    check("midrst_first_count_ok", (bcd_a == 12'h009 || bcd_a == 12'h010), 1'b1);
    wait_valid(c);
    check("midrst_steady_bcd_a", bcd_a, 12'h010);
    check("midrst_steady_bcd_b", bcd_b, 4'h9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
